// File: rtl/ddr_load_scheduler_if.sv
// Bundles the descriptor handshake, axi_mst job registers and the reader steering
// signals of ddr_load_scheduler into one port.
interface ddr_load_scheduler_if #(
  parameter int FW   = 253,
  parameter int CU_W = 6
);
  logic            desc_valid;
  logic            desc_ready;
  logic [FW-1:0]   desc_data;
  logic            rd_start;
  logic [31:0]     rd_addr;
  logic [31:0]     rd_nburst;
  logic            rd_idle;
  logic            load_mode;
  logic [CU_W-1:0] cu_sel;
  logic            busy;
  logic            done;

  modport master (
    output desc_valid, desc_data, rd_idle,
    input  desc_ready, rd_start, rd_addr, rd_nburst, load_mode, cu_sel, busy, done
  );

  modport slave (
    input  desc_valid, desc_data, rd_idle,
    output desc_ready, rd_start, rd_addr, rd_nburst, load_mode, cu_sel, busy, done
  );
endinterface

// File: rtl/ddr_load_scheduler.sv
// Splits one layer descriptor into weight and feature-map DDR read jobs of at most
// UNIT_BURSTS bursts and hands them to axi_mst one at a time.
module ddr_load_scheduler #(
  parameter int FW          = 253,
  parameter int N_CONV_UNIT = 64,
  parameter int UNIT_BURSTS = 2048,
  parameter int BURST_BYTES = 128
) (
  input logic                 clk,
  input logic                 rst,
  ddr_load_scheduler_if.slave bus
);
  localparam int CU_W     = (N_CONV_UNIT > 1) ? $clog2(N_CONV_UNIT) : 1;
  localparam int BB_SHIFT = $clog2(BURST_BYTES);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WEI_REQ  = 3'd1;
  localparam logic [2:0] S_WEI_WAIT = 3'd2;
  localparam logic [2:0] S_FM_REQ   = 3'd3;
  localparam logic [2:0] S_FM_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [31:0]     wei_addr_q, wei_addr_d;
  logic [31:0]     fm_addr_q, fm_addr_d;
  logic [12:0]     wei_rem_q, wei_rem_d;
  logic [24:0]     fm_rem_q, fm_rem_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic [31:0]     rd_nburst_q, rd_nburst_d;
  logic [CU_W-1:0] cu_sel_q, cu_sel_d;

  logic [31:0]     desc_wei_addr, desc_fm_addr;
  logic [12:0]     desc_wei_nb;
  logic [24:0]     desc_fm_nb;
  logic [31:0]     job_bytes;
  logic [31:0]     wei_addr_nxt, fm_addr_nxt;
  logic [12:0]     wei_rem_nxt;
  logic [24:0]     fm_rem_nxt;
  logic [CU_W-1:0] cu_sel_inc;
  logic            unused_desc_bits;

  assign desc_wei_addr = bus.desc_data[31:0];
  assign desc_wei_nb   = bus.desc_data[51:39];
  assign desc_fm_addr  = bus.desc_data[95:64];
  assign desc_fm_nb    = bus.desc_data[127:103];
  assign unused_desc_bits = ^{bus.desc_data[FW-1:128], bus.desc_data[102:96],
                              bus.desc_data[63:52], bus.desc_data[38:32]};

  // Address/remaining values that take effect once the current job has drained.
  assign job_bytes    = rd_nburst_q << BB_SHIFT;
  assign wei_addr_nxt = wei_addr_q + job_bytes;
  assign fm_addr_nxt  = fm_addr_q + job_bytes;
  assign wei_rem_nxt  = wei_rem_q - rd_nburst_q[12:0];
  assign fm_rem_nxt   = fm_rem_q - rd_nburst_q[24:0];
  assign cu_sel_inc   = (cu_sel_q == CU_W'(N_CONV_UNIT - 1)) ? '0 : cu_sel_q + 1'b1;

  function automatic logic [31:0] job_len(input logic [31:0] remaining);
    if (remaining > 32'(UNIT_BURSTS)) return 32'(UNIT_BURSTS);
    return remaining;
  endfunction

  always_comb begin
    state_d     = state_q;
    wei_addr_d  = wei_addr_q;
    fm_addr_d   = fm_addr_q;
    wei_rem_d   = wei_rem_q;
    fm_rem_d    = fm_rem_q;
    rd_addr_d   = rd_addr_q;
    rd_nburst_d = rd_nburst_q;
    cu_sel_d    = cu_sel_q;
    case (state_q)
      S_IDLE: begin
        if (bus.desc_valid) begin
          wei_addr_d = desc_wei_addr;
          fm_addr_d  = desc_fm_addr;
          wei_rem_d  = desc_wei_nb;
          fm_rem_d   = desc_fm_nb;
          cu_sel_d   = '0;
          if (desc_wei_nb != '0) begin
            state_d     = S_WEI_REQ;
            rd_addr_d   = desc_wei_addr;
            rd_nburst_d = job_len({19'd0, desc_wei_nb});
          end else if (desc_fm_nb != '0) begin
            state_d     = S_FM_REQ;
            rd_addr_d   = desc_fm_addr;
            rd_nburst_d = job_len({7'd0, desc_fm_nb});
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WEI_REQ: if (!bus.rd_idle) state_d = S_WEI_WAIT;
      S_FM_REQ:  if (!bus.rd_idle) state_d = S_FM_WAIT;
      S_WEI_WAIT: begin
        if (bus.rd_idle) begin
          wei_addr_d = wei_addr_nxt;
          wei_rem_d  = wei_rem_nxt;
          if (wei_rem_nxt != '0) begin
            state_d     = S_WEI_REQ;
            cu_sel_d    = cu_sel_inc;
            rd_addr_d   = wei_addr_nxt;
            rd_nburst_d = job_len({19'd0, wei_rem_nxt});
          end else if (fm_rem_q != '0) begin
            state_d     = S_FM_REQ;
            rd_addr_d   = fm_addr_q;
            rd_nburst_d = job_len({7'd0, fm_rem_q});
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FM_WAIT: begin
        if (bus.rd_idle) begin
          fm_addr_d = fm_addr_nxt;
          fm_rem_d  = fm_rem_nxt;
          if (fm_rem_nxt != '0) begin
            state_d     = S_FM_REQ;
            rd_addr_d   = fm_addr_nxt;
            rd_nburst_d = job_len({7'd0, fm_rem_nxt});
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wei_addr_q  <= '0;
      fm_addr_q   <= '0;
      wei_rem_q   <= '0;
      fm_rem_q    <= '0;
      rd_addr_q   <= '0;
      rd_nburst_q <= '0;
      cu_sel_q    <= '0;
    end else begin
      state_q     <= state_d;
      wei_addr_q  <= wei_addr_d;
      fm_addr_q   <= fm_addr_d;
      wei_rem_q   <= wei_rem_d;
      fm_rem_q    <= fm_rem_d;
      rd_addr_q   <= rd_addr_d;
      rd_nburst_q <= rd_nburst_d;
      cu_sel_q    <= cu_sel_d;
    end
  end

  assign bus.desc_ready = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.rd_start   = (state_q == S_WEI_REQ) || (state_q == S_FM_REQ);
  assign bus.load_mode  = (state_q == S_FM_REQ) || (state_q == S_FM_WAIT);
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_nburst  = rd_nburst_q;
  assign bus.cu_sel     = cu_sel_q;
endmodule
